// File: rtl/cart_save_ctrl.sv
// SD-card block sequencer for a cartridge save image: load on mount, per-sector dirty tracking, write-back.
// Optional CART_SAVE_WDOG_EN adds a request watchdog and a sticky err output.
module cart_save_ctrl #(
  parameter int SECTORS      = 4,
  parameter int IDLE_TIMEOUT = 3200000,
  localparam int SW = (SECTORS > 1) ? $clog2(SECTORS) : 1,
  localparam int AW = 9 + $clog2(SECTORS)
) (
  input  logic          clk32,
  input  logic          reset,
  input  logic          img_mounted,
  input  logic          img_valid,
  input  logic          img_readonly,
  input  logic          autosave,
  input  logic          save_req,
  input  logic          dirty_wr,
  input  logic [AW-1:0] dirty_addr,
  output logic [31:0]   sd_lba,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [8:0]    sd_buff_addr,
  input  logic [7:0]    sd_buff_dout,
  input  logic          sd_buff_wr,
  output logic [7:0]    sd_buff_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
`ifdef CART_SAVE_WDOG_EN
  output logic          err,
`endif
  output logic          loaded
);

  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_XFER, SAVE_SCAN, SAVE_REQ, SAVE_XFER} state_t;

  localparam logic [23:0]   TO   = 24'(IDLE_TIMEOUT);
  localparam logic [SW-1:0] LAST = SW'(SECTORS - 1);

  state_t              state, state_n;
  logic [SW-1:0]       sector, sector_n, low_dirty, wsec;
  logic [SECTORS-1:0]  dirty, dset, dclr;
  logic                ro, valid, new_ro, new_valid, loaded_q;
  logic                mount_pend, save_pend;
  logic [23:0]         idle_cnt;
  logic                restart, skip_load, load_done, ack_clr, take_save;
  logic                mount_any, any_dirty, save_go;
  logic [SW+8:0]       addr_cat;
  logic                unused_bits;
`ifdef CART_SAVE_WDOG_EN
  logic [19:0]         wd;
  logic                wd_fire;
`endif

  generate
    if (SECTORS > 1) begin : g_wsec
      assign wsec = dirty_addr[AW-1:9];
    end else begin : g_wsec1
      assign wsec = '0;
    end
  endgenerate
  assign unused_bits = ^dirty_addr[8:0];

  assign mount_any = img_mounted | mount_pend;
  assign any_dirty = |dirty;
  assign save_go   = !ro && loaded_q && any_dirty &&
                     (save_req || save_pend || (autosave && idle_cnt == TO));

  always_comb begin
    low_dirty = '0;
    for (int i = SECTORS - 1; i >= 0; i--)
      if (dirty[i]) low_dirty = SW'(i);
  end

  always_comb begin
    dset = '0;
    dclr = '0;
    if (dirty_wr && loaded_q && int'(wsec) < SECTORS) dset[wsec] = 1'b1;
    if (ack_clr) dclr[sector] = 1'b1;
  end

  always_comb begin
    state_n   = state;
    sector_n  = sector;
    restart   = 1'b0;
    skip_load = 1'b0;
    load_done = 1'b0;
    ack_clr   = 1'b0;
    take_save = 1'b0;
`ifdef CART_SAVE_WDOG_EN
    wd_fire   = 1'b0;
`endif
    case (state)
      IDLE:
        if (mount_any) begin
          state_n = LOAD_REQ; sector_n = '0; restart = 1'b1;
        end else if (save_go) begin
          state_n = SAVE_SCAN; take_save = 1'b1;
        end
      LOAD_REQ:
        if (!valid) begin
          skip_load = 1'b1; state_n = IDLE;
        end else if (sd_ack) state_n = LOAD_XFER;
`ifdef CART_SAVE_WDOG_EN
        else if (wd == '1) begin wd_fire = 1'b1; state_n = IDLE; end
`endif
      LOAD_XFER:
        if (!sd_ack) begin
          if (mount_any) begin
            state_n = LOAD_REQ; sector_n = '0; restart = 1'b1;
          end else if (sector == LAST) begin
            load_done = 1'b1; state_n = IDLE;
          end else begin
            sector_n = sector + 1'b1; state_n = LOAD_REQ;
          end
        end
      SAVE_SCAN:
        if (mount_any) begin
          state_n = LOAD_REQ; sector_n = '0; restart = 1'b1;
        end else if (!any_dirty) state_n = IDLE;
        else begin
          sector_n = low_dirty; state_n = SAVE_REQ;
        end
      SAVE_REQ:
        if (sd_ack) begin
          ack_clr = 1'b1; state_n = SAVE_XFER;
        end
`ifdef CART_SAVE_WDOG_EN
        else if (wd == '1) begin wd_fire = 1'b1; state_n = IDLE; end
`endif
      SAVE_XFER:
        if (!sd_ack) begin
          if (mount_any) begin
            state_n = LOAD_REQ; sector_n = '0; restart = 1'b1;
          end else state_n = SAVE_SCAN;
        end
      default: state_n = IDLE;
    endcase
  end

  // ro/valid only change when a load (re)starts, so an in-flight request never sees them flip
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sector     <= '0;
      dirty      <= '0;
      ro         <= 1'b0;
      valid      <= 1'b0;
      new_ro     <= 1'b0;
      new_valid  <= 1'b0;
      loaded_q   <= 1'b0;
      mount_pend <= 1'b0;
      save_pend  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state  <= state_n;
      sector <= sector_n;
      if (img_mounted) begin
        new_ro    <= img_readonly;
        new_valid <= img_valid;
      end
      if (restart) begin
        ro    <= img_mounted ? img_readonly : new_ro;
        valid <= img_mounted ? img_valid    : new_valid;
      end
      mount_pend <= !restart && mount_any;
      if (img_mounted)                 loaded_q <= 1'b0;
      else if (skip_load || load_done) loaded_q <= 1'b1;
      if (skip_load)      dirty <= '1;
      else if (load_done) dirty <= '0;
      else                dirty <= (dirty & ~dclr) | dset;
      if (take_save || restart) save_pend <= 1'b0;
      else if (save_req)        save_pend <= 1'b1;
      else if (state == IDLE)   save_pend <= 1'b0;
      if (dirty_wr)          idle_cnt <= '0;
      else if (idle_cnt != TO) idle_cnt <= idle_cnt + 1'b1;
    end
  end

`ifdef CART_SAVE_WDOG_EN
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= (((state == LOAD_REQ) && valid) || state == SAVE_REQ) && !sd_ack ? wd + 1'b1 : '0;
      if (img_mounted)  err <= 1'b0;
      else if (wd_fire) err <= 1'b1;
    end
  end
`endif

  assign addr_cat    = {sector, sd_buff_addr};
  assign sd_rd       = (state == LOAD_REQ) && valid;
  assign sd_wr       = (state == SAVE_REQ);
  assign sd_lba      = (state == LOAD_REQ || state == LOAD_XFER ||
                        state == SAVE_REQ || state == SAVE_XFER) ? 32'(sector) : '0;
  assign mem_addr    = (state == IDLE) ? '0 : addr_cat[AW-1:0];
  assign mem_we      = (state == LOAD_XFER) && sd_ack && sd_buff_wr;
  assign mem_wdata   = sd_buff_dout;
  assign sd_buff_din = mem_rdata;
  assign busy        = (state != IDLE);
  assign loaded      = loaded_q;

endmodule

// File: doc/cart_save_ctrl.md
Name: cart_save_ctrl

Overview:
Sequences SD-card block transfers for a cartridge's non-volatile save memory (for example, the GMOD2 2 KB serial EEPROM image). The block sits between the cartridge mapper, the external save buffer RAM and the HPS sd_* block interface.
- On image mount it loads every sector into the buffer.
- It tracks cartridge writes per 512-byte sector.
- It writes dirty sectors back on manual request, or automatically after write activity has gone quiet.

Parameters:
SECTORS, 4, number of 512-byte sectors in the save image (1..16); buffer address width is 9+clog2(SECTORS)
IDLE_TIMEOUT, 3200000, clk32 cycles of no dirty_wr before an autosave starts (100 ms at 32 MHz); 24-bit counter

Ports:
clk32  in  1  system clock
reset  in  1  asynchronous, active-high reset
img_mounted  in  1  one-cycle pulse: save image (re)mounted
img_valid  in  1  mounted image has nonzero size; sampled on img_mounted
img_readonly  in  1  image is write-protected; sampled on img_mounted
autosave  in  1  enables timed write-back
save_req  in  1  one-cycle pulse: flush all dirty sectors
dirty_wr  in  1  cartridge write strobe to the save memory
dirty_addr  in  AW  byte address of that write
sd_lba  out  32  sector number for the current transfer
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  HPS transfer acknowledge
sd_buff_addr  in  9  HPS byte index within the sector
sd_buff_dout  in  8  HPS read data
sd_buff_wr  in  1  HPS read-data strobe
sd_buff_din  out  8  write data to the HPS (combinational from mem_rdata)
mem_addr  out  AW  buffer address {sector, sd_buff_addr}
mem_we  out  1  buffer write enable
mem_wdata  out  8  buffer write data (sd_buff_dout)
mem_rdata  in  8  buffer read data; combinational from mem_addr
busy  out  1  any state other than IDLE
loaded  out  1  buffer contents valid

Behaviour:
Reset values:
- All outputs are 0 and the state is IDLE.
- dirty[SECTORS-1:0] = 0, ro = 0, mount_pend = 0, idle_cnt = 0.
- An asynchronous reset mid-transfer drops sd_rd/sd_wr immediately; the HPS is expected to be reset alongside.

States:
- IDLE, LOAD_REQ, LOAD_XFER, SAVE_SCAN, SAVE_REQ, SAVE_XFER.

Handshake (both directions):
- Assert sd_rd or sd_wr and hold it until sd_ack rises; deassert it in the cycle after sd_ack=1 is seen.
- Data moves while sd_ack=1.
- The transfer is complete on the first cycle with sd_ack=0 after it was 1.
- sd_lba is stable from the request until completion.

Load path:
- img_mounted in IDLE: latch ro and valid, clear loaded, go to LOAD_REQ with sector 0.
- If valid=0, skip the load: set all dirty bits, set loaded, return to IDLE. The first save then creates the image.
- LOAD_XFER: mem_we = sd_ack & sd_buff_wr; mem_addr = {sector, sd_buff_addr}.
- On completion: sector+1. After sector SECTORS-1, clear dirty, set loaded, go to IDLE.
- img_mounted while busy sets mount_pend. The current transfer completes, the remaining sequence is abandoned, and the load restarts from sector 0.

Dirty tracking:
- dirty_wr with loaded=1 sets dirty[dirty_addr[AW-1:9]].
- dirty_wr during a load is ignored.

Save path:
- Entered from IDLE when ro=0, loaded=1, dirty≠0, and either:
  - save_req was seen (latched while busy), or
  - autosave=1 and idle_cnt has reached IDLE_TIMEOUT.
- idle_cnt clears on any dirty_wr and saturates at IDLE_TIMEOUT.
- SAVE_SCAN: select the lowest-index dirty sector; if none is dirty, go to IDLE.
- SAVE_REQ: sd_wr=1.
- Clear that sector's dirty bit on the sd_ack rising edge. A dirty_wr in the same cycle, or later, re-sets it (set wins), so the sector is saved again.
- After completion return to SAVE_SCAN.

Read-only image:
- save_req and autosave are ignored.
- Dirty bits still accumulate.

mem_we is 0 in all states except LOAD_XFER. In IDLE, mem_addr is 0.

Optional Feature:
CART_SAVE_WDOG_EN:
- Defined:
  - A 20-bit watchdog counts cycles in LOAD_REQ and SAVE_REQ while sd_ack=0.
  - At 2^20-1 it drops the request, sets the output err (1 bit, sticky until the next img_mounted or reset) and returns to IDLE.
  - A save timeout leaves dirty intact. A load timeout leaves loaded=0.
- Undefined:
  - No err port; requests wait for sd_ack indefinitely.

Test Plan:
- Mount with valid=1, SECTORS=4 → four sd_rd transfers with sd_lba 0,1,2,3; buffer filled with the HPS pattern; loaded=1; dirty=0.
- Mount with valid=0 → no sd_rd, loaded=1 at once, dirty=4'b1111; save_req → four sd_wr transfers with lba 0..3 and sd_buff_din matching the buffer.
- dirty_wr to addr 0x3FF and 0x005, then save_req → sd_wr with lba 0 then lba 1 only; dirty=0 afterwards.
- autosave=1, IDLE_TIMEOUT=100, single dirty_wr → sd_wr begins exactly 100 cycles later; a dirty_wr at cycle 50 delays the start to cycle 150.
- dirty_wr to sector 2 while sector 2 is in SAVE_XFER → second sd_wr for lba 2 follows; img_readonly=1 → save_req produces no sd_wr.
- img_mounted during a save of sector 1 → sector 1 completes, then the load restarts at lba 0; with CART_SAVE_WDOG_EN and sd_ack held low → err=1 after 2^20-1 cycles, busy=0.
